// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer and the downstream output decoder:
// state codes, opcode values and instruction-word field positions.
package control_sequencer_pkg;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00000,
    S_LOAD     = 5'b00001,
    S_MOVE     = 5'b00010,
    S_LDPC     = 5'b00011,
    S_BRANCH   = 5'b00100,
    S_ADD1     = 5'b00101,
    S_ADD2     = 5'b00110,
    S_ADD3     = 5'b00111,
    S_XOR1     = 5'b01000,
    S_XOR2     = 5'b01001,
    S_XOR3     = 5'b01010,
    S_SUB1     = 5'b01011,
    S_SUB2     = 5'b01100,
    S_SUB3     = 5'b01101,
    S_MUL1     = 5'b01110,
    S_MUL2     = 5'b01111,
    S_MUL3     = 5'b10000,
    S_DIV1     = 5'b10001,
    S_DIV2     = 5'b10010,
    S_DIV3     = 5'b10011,
    S_ONES1    = 5'b10100,
    S_ONES2    = 5'b10101,
    S_ONES3    = 5'b10110,
    S_ONESALL1 = 5'b10111,  // clear the register-index counter
    S_ONESALL2 = 5'b11000,  // decoder enables the counter -> count = 1
    S_ONESALL3 = 5'b11001,  // loop decision on count
    S_ONESALL4 = 5'b11010,
    S_ONESALL5 = 5'b11011,
    S_ONESALL6 = 5'b11100,  // counter increments here
    S_ONESALL7 = 5'b11101   // loop exit
  } state_t;

  localparam logic [3:0] OP_LOAD    = 4'd0;
  localparam logic [3:0] OP_MOVE    = 4'd1;
  localparam logic [3:0] OP_LDPC    = 4'd2;
  localparam logic [3:0] OP_BRANCH  = 4'd3;
  localparam logic [3:0] OP_ADD     = 4'd4;
  localparam logic [3:0] OP_XOR     = 4'd5;
  localparam logic [3:0] OP_SUB     = 4'd6;
  localparam logic [3:0] OP_MUL     = 4'd7;
  localparam logic [3:0] OP_DIV     = 4'd8;
  localparam logic [3:0] OP_ONES    = 4'd9;
  localparam logic [3:0] OP_ONESALL = 4'd10;

  // Instruction word field positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 8;
  localparam int RY_MSB  = 7;
  localparam int RY_LSB  = 4;

endpackage

// File: rtl/control_next_state.sv
// Purely combinational next-state logic for the control sequencer.
// Hold and reset are applied by the parent, which owns the registers.
module control_next_state
  import control_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS        = 8,
  parameter bit          IDLE_ON_ILLEGAL = 1'b1
) (
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_run,
  input  logic [3:0] i_count,
  output state_t     o_next_state,
  output logic       o_illegal_next
);

  localparam logic [3:0] LP_LAST = 4'(NUM_REGS);

  // Next state and illegal-opcode flag from current state and inputs.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    o_next_state   = S_IDLE;
    o_illegal_next = 1'b0;
    case (i_state)
      S_IDLE: begin
        if (i_run) begin
          case (i_opcode)
            OP_LOAD:    o_next_state = S_LOAD;
            OP_MOVE:    o_next_state = S_MOVE;
            OP_LDPC:    o_next_state = S_LDPC;
            OP_BRANCH:  o_next_state = S_BRANCH;
            OP_ADD:     o_next_state = S_ADD1;
            OP_XOR:     o_next_state = S_XOR1;
            OP_SUB:     o_next_state = S_SUB1;
            OP_MUL:     o_next_state = S_MUL1;
            OP_DIV:     o_next_state = S_DIV1;
            OP_ONES:    o_next_state = S_ONES1;
            OP_ONESALL: o_next_state = S_ONESALL1;
            default:    o_illegal_next = IDLE_ON_ILLEGAL;
          endcase
        end
      end
      S_ADD1:     o_next_state = S_ADD2;
      S_ADD2:     o_next_state = S_ADD3;
      S_XOR1:     o_next_state = S_XOR2;
      S_XOR2:     o_next_state = S_XOR3;
      S_SUB1:     o_next_state = S_SUB2;
      S_SUB2:     o_next_state = S_SUB3;
      S_MUL1:     o_next_state = S_MUL2;
      S_MUL2:     o_next_state = S_MUL3;
      S_DIV1:     o_next_state = S_DIV2;
      S_DIV2:     o_next_state = S_DIV3;
      S_ONES1:    o_next_state = S_ONES2;
      S_ONES2:    o_next_state = S_ONES3;
      S_ONESALL1: o_next_state = S_ONESALL2;
      S_ONESALL2: o_next_state = S_ONESALL3;
      // >= rather than == so a runaway counter still terminates the loop.
      S_ONESALL3: o_next_state = (i_count >= LP_LAST) ? S_ONESALL7 : S_ONESALL4;
      S_ONESALL4: o_next_state = S_ONESALL5;
      S_ONESALL5: o_next_state = S_ONESALL6;
      S_ONESALL6: o_next_state = S_ONESALL3;
      // Single-state instructions, chain ends, loop exit and unused codes.
      default:    o_next_state = S_IDLE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: owns the state register and the latched instruction word
// that feed the output decoder, and steers the external register-index counter.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS        = 8,
  parameter bit          IDLE_ON_ILLEGAL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic [15:0] i_fncode_in,
  input  logic        i_hold,
  input  logic [3:0]  i_count,
  output logic [4:0]  o_state,
  output logic [15:0] o_fncode,
  output logic        o_busy,
  output logic        o_ctr_clr,
  output logic        o_illegal
);

  state_t      r_state;
  logic [15:0] r_fncode;
  logic        r_illegal;
  state_t      w_next_state;
  logic        w_illegal_next;
  logic        w_accept;

  control_next_state #(
    .NUM_REGS        (NUM_REGS),
    .IDLE_ON_ILLEGAL (IDLE_ON_ILLEGAL)
  ) u_next_state (
    .i_state        (r_state),
    .i_opcode       (i_fncode_in[OPC_MSB:OPC_LSB]),
    .i_run          (i_run),
    .i_count        (i_count),
    .o_next_state   (w_next_state),
    .o_illegal_next (w_illegal_next)
  );

  // An instruction is accepted only when IDLE leaves for a real state.
  assign w_accept = (r_state == S_IDLE) && (w_next_state != S_IDLE);

  // State, instruction latch and illegal pulse; reset beats hold beats advance.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values, independent of statement order.
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_fncode  <= '0;
      r_illegal <= 1'b0;
    end else if (i_hold) begin
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= w_illegal_next;
      if (w_accept) begin
        r_fncode <= i_fncode_in;
      end
    end
  end

  assign o_state   = r_state;
  assign o_fncode  = r_fncode;
  assign o_illegal = r_illegal;
  assign o_busy    = (r_state != S_IDLE);
  assign o_ctr_clr = i_reset || (r_state == S_ONESALL1);

endmodule
